// File: rtl/pipeline_issue_controller.sv
// Issue control between fetch and decode: inserts load-use bubbles, squashes
// wrong-path slots after a jump, and keeps saturating debug counters.
module pipeline_issue_controller #(
  parameter logic [4:0]  LOAD_OP      = 5'b10100,
  parameter logic [4:0]  STORE_OP     = 5'b10101,
  parameter logic [4:0]  JUMP_OP      = 5'b11000,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned BR_PENALTY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [19:0] if_ins,
  output logic        if_ready,
  output logic        issue_valid,
  output logic [19:0] issue_ins,
  output logic        flush,
  output logic [7:0]  stall_cnt,
  output logic [7:0]  flush_cnt
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  typedef struct packed {
    logic       v;
    logic       is_load;
    logic [4:0] rw;
  } sb_entry_t;

  state_t     state, state_nx;
  logic [1:0] scnt, scnt_nx, fcnt, fcnt_nx;
  sb_entry_t  sb [3];
  logic       issue, stall_slot, flush_slot, hazard, use_ra, use_rb;
  logic [4:0] op, ra, rb;

  assign op = if_ins[19:15];
  assign ra = if_ins[9:5];
  assign rb = if_ins[4:0];

  always_comb begin
    use_ra = !((op == 5'b00000) || (op == JUMP_OP));
    use_rb = use_ra && (op[4:3] != 2'b01);
    hazard = 1'b0;
    // Entry i is only consulted while the load result is still unforwardable.
    for (int unsigned i = 0; i < 3; i++) begin
      if ((i < LOAD_BUBBLES) && sb[i].v && sb[i].is_load &&
          ((use_ra && (sb[i].rw == ra)) || (use_rb && (sb[i].rw == rb))))
        hazard = 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    scnt_nx    = scnt;
    fcnt_nx    = fcnt;
    issue      = 1'b0;
    stall_slot = 1'b0;
    flush_slot = 1'b0;
    if_ready   = 1'b1;
    case (state)
      RUN: begin
        if (if_valid) begin
          if (hazard) begin
            stall_slot = 1'b1;
            if_ready   = 1'b0;
            // A single bubble needs no STALL visit: RUN re-evaluates next cycle.
            if (LOAD_BUBBLES > 1) begin
              state_nx = STALL;
              scnt_nx  = 2'(LOAD_BUBBLES - 1);
            end
          end else begin
            issue = 1'b1;
            if (op == JUMP_OP) begin
              state_nx = FLUSH;
              fcnt_nx  = 2'(BR_PENALTY);
            end
          end
        end
      end
      STALL: begin
        if_ready   = 1'b0;
        stall_slot = 1'b1;
        scnt_nx    = scnt - 2'd1;
        if (scnt <= 2'd1) state_nx = RUN;
      end
      FLUSH: begin
        flush_slot = 1'b1;
        fcnt_nx    = fcnt - 2'd1;
        if (fcnt <= 2'd1) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      scnt        <= '0;
      fcnt        <= '0;
      issue_valid <= 1'b0;
      issue_ins   <= '0;
      flush       <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      for (int unsigned i = 0; i < 3; i++) sb[i] <= '0;
    end else begin
      state       <= state_nx;
      scnt        <= scnt_nx;
      fcnt        <= fcnt_nx;
      issue_valid <= issue;
      issue_ins   <= issue ? if_ins : '0;
      flush       <= flush_slot;
      if (stall_slot && (stall_cnt != '1)) stall_cnt <= stall_cnt + 8'd1;
      if (flush_slot && (flush_cnt != '1)) flush_cnt <= flush_cnt + 8'd1;
      // Stores write no register, so they never occupy a producer slot.
      sb[0].v       <= issue && (op != STORE_OP);
      sb[0].is_load <= (op == LOAD_OP);
      sb[0].rw      <= if_ins[14:10];
      sb[1]         <= sb[0];
      sb[2]         <= sb[1];
    end
  end

endmodule
